// File: rtl/oserdes_lane_sequencer.sv
// OSERDESE2 lane bank sequencer: reset, OCE, flush, training, then payload streaming with idle fill.
// Optional per-lane PRBS7 payload source is compiled in with `define OSER_PRBS_EN (adds prbs_mode).

module oserdes_lane_sequencer_lane #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE       = '0,
  parameter logic [DATA_WIDTH-1:0] TRAIN      = '0
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] data,
`ifdef OSER_PRBS_EN
  input  logic                  reseed,
  input  logic [6:0]            seed,
`endif
  output logic [DATA_WIDTH-1:0] d
);
  localparam logic [1:0] SEL_TRAIN = 2'd1;
  localparam logic [1:0] SEL_DATA  = 2'd2;
  localparam logic [1:0] SEL_PRBS  = 2'd3;

`ifdef OSER_PRBS_EN
  logic [6:0]            lfsr, lfsr_nxt;
  logic [DATA_WIDTH-1:0] prbs_word;

  // x^7+x^6+1, DATA_WIDTH steps per cycle, first generated bit lands in the LSB
  always_comb begin
    lfsr_nxt  = lfsr;
    prbs_word = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      prbs_word[b] = lfsr_nxt[6] ^ lfsr_nxt[5];
      lfsr_nxt     = {lfsr_nxt[5:0], prbs_word[b]};
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n || reseed) lfsr <= seed;
    else if (sel == SEL_PRBS) lfsr <= lfsr_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!srst_n) d <= IDLE;
    else begin
      case (sel)
        SEL_TRAIN: d <= TRAIN;
        SEL_DATA:  d <= data;
`ifdef OSER_PRBS_EN
        SEL_PRBS:  d <= prbs_word;
`endif
        default:   d <= IDLE;
      endcase
    end
  end
endmodule

module oserdes_lane_sequencer #(
  parameter int          NUM_LANES    = 4,
  parameter int          DATA_WIDTH   = 8,
  parameter int          RST_CYCLES   = 8,
  parameter int          FLUSH_CYCLES = 4,
  parameter int          TRAIN_WORDS  = 16,
  parameter logic [7:0]  IDLE_WORD    = 8'h00,
  parameter logic [7:0]  TRAIN_WORD   = 8'h5A
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
`ifdef OSER_PRBS_EN
  input  logic                            prbs_mode,
`endif
  output logic                            oser_rst,
  output logic                            oser_oce,
  output logic [NUM_LANES*DATA_WIDTH-1:0] oser_d,
  output logic                            link_up,
  output logic                            busy,
  output logic [15:0]                     underflow_cnt
);
  localparam int PMAX0 = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
  localparam int PMAX  = (PMAX0 > TRAIN_WORDS) ? PMAX0 : TRAIN_WORDS;
  localparam int CW    = $clog2(PMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_TRAIN = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  localparam logic [1:0] SEL_IDLE  = 2'd0;
  localparam logic [1:0] SEL_TRAIN = 2'd1;
  localparam logic [1:0] SEL_DATA  = 2'd2;
  localparam logic [1:0] SEL_PRBS  = 2'd3;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          prbs_run, accept;
  logic [1:0]    sel;

`ifdef OSER_PRBS_EN
  assign prbs_run = (state == S_RUN) && prbs_mode;
`else
  assign prbs_run = 1'b0;
`endif

  assign s_ready = (state == S_RUN) && !stop && !prbs_run;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !stop) state_nxt = S_RESET;
      S_RESET: if (stop) state_nxt = S_IDLE;
               else if (cnt == CW'(RST_CYCLES - 1)) state_nxt = S_FLUSH;
      S_FLUSH: if (stop) state_nxt = S_IDLE;
               else if (cnt == CW'(FLUSH_CYCLES - 1)) state_nxt = S_TRAIN;
      S_TRAIN: if (stop) state_nxt = S_IDLE;
               else if (cnt == CW'(TRAIN_WORDS - 1)) state_nxt = S_RUN;
      S_RUN:   if (stop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane word for the next cycle; the first RUN cycle is always idle since nothing was offered in TRAIN
  always_comb begin
    sel = SEL_IDLE;
    if (state_nxt == S_TRAIN) sel = SEL_TRAIN;
    else if (state_nxt == S_RUN && state == S_RUN) begin
      if (prbs_run)    sel = SEL_PRBS;
      else if (accept) sel = SEL_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      oser_rst      <= 1'b1;
      oser_oce      <= 1'b0;
      link_up       <= 1'b0;
      busy          <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state    <= state_nxt;
      oser_rst <= (state_nxt == S_IDLE) || (state_nxt == S_RESET);
      oser_oce <= (state_nxt == S_FLUSH) || (state_nxt == S_TRAIN) || (state_nxt == S_RUN);
      link_up  <= (state_nxt == S_RUN);
      busy     <= (state_nxt == S_RESET) || (state_nxt == S_FLUSH) || (state_nxt == S_TRAIN);
      if (state_nxt != state) cnt <= '0;
      else if (state != S_IDLE && state != S_RUN) cnt <= cnt + CW'(1);
      if (state == S_IDLE && state_nxt == S_RESET) underflow_cnt <= '0;
      else if (state == S_RUN && !stop && !accept && !prbs_run && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

`ifdef OSER_PRBS_EN
  logic reseed;
  assign reseed = (state_nxt == S_RUN) && (state != S_RUN);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    oserdes_lane_sequencer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDLE       (IDLE_WORD[DATA_WIDTH-1:0]),
      .TRAIN      (TRAIN_WORD[DATA_WIDTH-1:0])
    ) u_lane (
      .clk    (clk),
      .srst_n (srst_n),
      .sel    (sel),
      .data   (s_data[i*DATA_WIDTH +: DATA_WIDTH]),
`ifdef OSER_PRBS_EN
      .reseed (reseed),
      .seed   (7'h7F ^ 7'(i)),
`endif
      .d      (oser_d[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_oserdes_lane_sequencer.sv
// Randomized scoreboard bench for oserdes_lane_sequencer; reference model tracks time since start.
module tb_oserdes_lane_sequencer;
  localparam int NL = 4, DW = 8, R = 8, F = 4, T = 16;
`ifdef OSER_PRBS_EN
  localparam bit PRBS = 1'b1;
`else
  localparam bit PRBS = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst_n, start, stop, s_valid, s_ready;
  logic [NL*DW-1:0] s_data, oser_d;
  logic oser_rst, oser_oce, link_up, busy;
  logic [15:0] underflow_cnt;
  logic prbs_mode;

  always #5 clk = ~clk;

  oserdes_lane_sequencer dut (
    .clk(clk), .srst_n(srst_n), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef OSER_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .oser_rst(oser_rst), .oser_oce(oser_oce), .oser_d(oser_d),
    .link_up(link_up), .busy(busy), .underflow_cnt(underflow_cnt)
  );

  typedef struct packed {
    logic rst, oce, link, busy;
    logic [15:0] uc;
    logic [NL*DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  // model: link phase is a pure function of cycles elapsed since start was accepted
  bit          m_active = 0;
  int          m_age = 0;
  logic [15:0] m_uc = '0;
  bit          hist[NL][7];

  function automatic int phase_of(int a);
    if (a < R) return 1;
    if (a < R + F) return 2;
    if (a < R + F + T) return 3;
    return 4;
  endfunction

  task automatic reseed_model();
    logic [6:0] s;
    for (int l = 0; l < NL; l++) begin
      s = 7'h7F ^ 7'(l);
      for (int k = 0; k < 7; k++) hist[l][k] = s[6-k];
    end
  endtask

  // PRBS7 as the recurrence b[n] = b[n-7] ^ b[n-6]
  task automatic prbs_words(output logic [NL*DW-1:0] w);
    bit nb;
    w = '0;
    for (int l = 0; l < NL; l++)
      for (int b = 0; b < DW; b++) begin
        nb = hist[l][0] ^ hist[l][1];
        for (int k = 0; k < 6; k++) hist[l][k] = hist[l][k+1];
        hist[l][6] = nb;
        w[l*DW + b] = nb;
      end
  endtask

  task automatic drive(input logic rn, st, sp, v, input logic [NL*DW-1:0] data, input logic pm);
    int cur, np;
    logic exp_rdy;
    logic [NL*DW-1:0] nd;
    exp_t e;
    @(negedge clk);
    srst_n = rn; start = st; stop = sp; s_valid = v; s_data = data; prbs_mode = pm;
    #1;
    cur = m_active ? phase_of(m_age) : 0;
    exp_rdy = (cur == 4) && !sp && !(PRBS && pm);
    n_cmp++;
    if (s_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL s_ready @%0t: got %b want %b", $time, s_ready, exp_rdy);
    end
    nd = '0;
    if (!rn) begin
      m_active = 0; m_uc = '0;
    end else if (!m_active) begin
      if (st && !sp) begin m_active = 1; m_age = 0; m_uc = '0; end
    end else if (sp) begin
      m_active = 0;
    end else begin
      if (cur == 4) begin
        if (PRBS && pm) prbs_words(nd);
        else if (v) nd = data;
        else if (m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
      end
      m_age++;
      if (cur == 3 && phase_of(m_age) == 4) reseed_model();
    end
    np = m_active ? phase_of(m_age) : 0;
    e.rst  = (np <= 1);
    e.oce  = (np >= 2);
    e.link = (np == 4);
    e.busy = (np >= 1 && np <= 3);
    e.uc   = m_uc;
    e.d    = (np == 3) ? {NL{8'h5A}} : ((np == 4) ? nd : '0);
    q.push_back(e);
  endtask

  task automatic idle_cyc(input int n, input logic v);
    for (int i = 0; i < n; i++) drive(1, 0, 0, v, NL*DW'($urandom), 0);
  endtask

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{oser_rst, oser_oce, link_up, busy, underflow_cnt, oser_d};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs @%0t: got rst=%b oce=%b link=%b busy=%b uc=%h d=%h want rst=%b oce=%b link=%b busy=%b uc=%h d=%h",
                 $time, g.rst, g.oce, g.link, g.busy, g.uc, g.d, e.rst, e.oce, e.link, e.busy, e.uc, e.d);
      end
    end
  end

  initial begin
    srst_n = 0; start = 0; stop = 0; s_valid = 0; s_data = '0; prbs_mode = 0;
    repeat (3) drive(0, 0, 0, 0, '0, 0);
    // bring-up, then three accepted words and idle fill
    drive(1, 1, 0, 0, '0, 0);
    idle_cyc(30, 0);
    repeat (3) drive(1, 0, 0, 1, 32'hDDCCBBAA, 0);
    idle_cyc(4, 0);
    // random payload in RUN with ignored start pulses
    for (int i = 0; i < 300; i++)
      drive(1, ($urandom_range(0, 9) == 0), 0, $urandom_range(0, 1), NL*DW'($urandom), 0);
    // stop during TRAIN, immediate relaunch
    drive(1, 0, 1, 0, '0, 0);
    drive(1, 1, 0, 0, '0, 0);
    idle_cyc(19, 1);
    drive(1, 0, 1, 1, '1, 0);
    drive(1, 1, 0, 0, '0, 0);
    idle_cyc(40, 0);
    // start and stop together in IDLE
    drive(1, 0, 1, 0, '0, 0);
    drive(1, 1, 1, 0, '0, 0);
    idle_cyc(3, 0);
    // synchronous reset while in FLUSH
    drive(1, 1, 0, 0, '0, 0);
    idle_cyc(9, 0);
    drive(0, 0, 0, 0, '0, 0);
    idle_cyc(3, 0);
    // random mix of everything
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0),
            $urandom_range(0, 1), NL*DW'($urandom), PRBS && ($urandom_range(0, 3) == 0));
    // saturation of the underflow counter
    drive(1, 0, 1, 0, '0, 0);
    drive(1, 1, 0, 0, '0, 0);
    idle_cyc(65600, 0);
    @(posedge clk); #2;
    n_cmp++;
    if (underflow_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL underflow_sat: got %h want ffff", underflow_cnt);
    end
    if (PRBS) begin
      drive(1, 0, 1, 0, '0, 0);
      drive(1, 1, 0, 0, '0, 0);
      idle_cyc(28, 0);
      for (int i = 0; i < 1000; i++) drive(1, 0, 0, $urandom_range(0, 1), NL*DW'($urandom), 1);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
